// File: rtl/cfc_pkg.sv
// Shared defaults and FSM encoding for the CFC rename checkpoint RAM.
package cfc_pkg;

    localparam int CFC_NUM_CKPT   = 8;
    localparam int CFC_NUM_AREG   = 32;
    localparam int CFC_DOUT_WIDTH = 6;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        COPY = 2'd2
    } cfc_state_e;

endpackage

// File: rtl/cfc_bram_1w1r.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module cfc_bram_1w1r
    import cfc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DOUT_WIDTH = CFC_DOUT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DOUT_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DOUT_WIDTH-1:0] rdata_o
);

    (* ram_style = "block" *) logic [DOUT_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DOUT_WIDTH-1:0] rdata_q;

    // Array write; storage itself carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register sees the pre-write contents on an address collision.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cfc_ckpt_ram.sv
// Checkpoint RAM for the CFC rename front end: NUM_RD read ports, init sweep, copy engine.
// Optional write-first forwarding on the read ports: define CFC_CKPT_RAM_WR_FWD_EN.
module cfc_ckpt_ram
    import cfc_pkg::*;
#(
    parameter int  NUM_CKPT      = CFC_NUM_CKPT,
    parameter int  NUM_AREG      = CFC_NUM_AREG,
    parameter int  DOUT_WIDTH    = CFC_DOUT_WIDTH,
    parameter int  NUM_RD        = 2,
    parameter int  INIT_IDENTITY = 1,
    localparam int CKPT_W        = $clog2(NUM_CKPT),
    localparam int AREG_W        = $clog2(NUM_AREG)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         ready,
    input  logic                         wr_en,
    input  logic [CKPT_W-1:0]            wr_ckpt,
    input  logic [AREG_W-1:0]            wr_areg,
    input  logic [DOUT_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*CKPT_W-1:0]     rd_ckpt,
    input  logic [NUM_RD*AREG_W-1:0]     rd_areg,
    output logic [NUM_RD*DOUT_WIDTH-1:0] rd_data,
    input  logic                         copy_req,
    input  logic [CKPT_W-1:0]            copy_src,
    input  logic [CKPT_W-1:0]            copy_dst,
    output logic                         copy_done
);

    localparam int ADDR_W  = CKPT_W + AREG_W;
    localparam int NUM_ENT = NUM_CKPT * NUM_AREG;

    cfc_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [CKPT_W-1:0]     src_q, src_d;
    logic [CKPT_W-1:0]     dst_q, dst_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    logic                  copy_last_s;
    logic                  mem_we_s;
    logic                  mem_wr_s;
    logic [ADDR_W-1:0]     mem_waddr_s;
    logic [DOUT_WIDTH-1:0] mem_wdata_s;
    logic [ADDR_W-1:0]     cp_raddr_s;
    logic [DOUT_WIDTH-1:0] cp_rdata_s;

    assign copy_last_s = (cnt_q[AREG_W-1:0] == AREG_W'(NUM_AREG - 1));

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic for the init sweep and copy engine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            INIT: begin
                if (cnt_q == ADDR_W'(NUM_ENT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (copy_req && (copy_src != copy_dst)) begin
                    state_d = COPY;
                    cnt_d   = '0;
                    src_d   = copy_src;
                    dst_d   = copy_dst;
                end else begin
                    state_d = IDLE;
                end
            end
            COPY: begin
                if (copy_last_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: shared write port mux, copy read address, status strobes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = '0;
        cp_raddr_s  = {copy_src, AREG_W'(0)};
        done_d      = 1'b0;
        ready_d     = (state_d == IDLE);
        case (state_q)
            INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q;
                if (INIT_IDENTITY != 0) begin
                    mem_wdata_s = DOUT_WIDTH'(cnt_q[AREG_W-1:0]);
                end else begin
                    mem_wdata_s = '0;
                end
            end
            IDLE: begin
                mem_we_s    = wr_en;
                mem_waddr_s = {wr_ckpt, wr_areg};
                mem_wdata_s = wr_data;
                cp_raddr_s  = {copy_src, AREG_W'(0)};
                done_d      = copy_req && (copy_src == copy_dst);
            end
            COPY: begin
                // Data read last cycle for entry cnt lands now; fetch entry cnt+1 in parallel.
                mem_we_s    = 1'b1;
                mem_waddr_s = {dst_q, cnt_q[AREG_W-1:0]};
                mem_wdata_s = cp_rdata_s;
                cp_raddr_s  = {src_q, cnt_q[AREG_W-1:0] + AREG_W'(1)};
                done_d      = copy_last_s;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    assign mem_wr_s  = mem_we_s & rst_n;
    assign ready     = ready_q;
    assign copy_done = done_q;

    cfc_bram_1w1r #(
        .ADDR_WIDTH (ADDR_W),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_copy_bram (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (mem_wr_s),
        .waddr_i (mem_waddr_s),
        .wdata_i (mem_wdata_s),
        .raddr_i (cp_raddr_s),
        .rdata_o (cp_rdata_s)
    );

`ifdef CFC_CKPT_RAM_WR_FWD_EN
    logic [DOUT_WIDTH-1:0] fwd_data_q;

    // Last written value, shared by all read ports for write-first bypass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_data_q <= '0;
        end else begin
            fwd_data_q <= mem_wdata_s;
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0]     rd_addr_s;
        logic [DOUT_WIDTH-1:0] bram_rdata_s;

        assign rd_addr_s = {rd_ckpt[k*CKPT_W +: CKPT_W], rd_areg[k*AREG_W +: AREG_W]};

        cfc_bram_1w1r #(
            .ADDR_WIDTH (ADDR_W),
            .DOUT_WIDTH (DOUT_WIDTH)
        ) u_bram (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .we_i    (mem_wr_s),
            .waddr_i (mem_waddr_s),
            .wdata_i (mem_wdata_s),
            .raddr_i (rd_addr_s),
            .rdata_o (bram_rdata_s)
        );

`ifdef CFC_CKPT_RAM_WR_FWD_EN
        logic fwd_hit_q;

        // Flag a same-cycle write to this port's read address.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                fwd_hit_q <= 1'b0;
            end else begin
                fwd_hit_q <= mem_wr_s && (mem_waddr_s == rd_addr_s);
            end
        end

        assign rd_data[k*DOUT_WIDTH +: DOUT_WIDTH] = fwd_hit_q ? fwd_data_q : bram_rdata_s;
`else
        assign rd_data[k*DOUT_WIDTH +: DOUT_WIDTH] = bram_rdata_s;
`endif
    end

endmodule
